// File: rtl/request_arbiter_if.sv
// Request/grant bundle between request sources, the arbiter and the
// grant consumer (one-hot-to-index decoder side).
interface request_arbiter_if #(
    parameter int N = 32
);
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         ack;
    logic [N-1:0] grant;
    logic         valid;
    logic [N-1:0] pending;
    logic [4:0]   ptr;

    modport master (
        output req,
        output mask,
        output ack,
        input  grant,
        input  valid,
        input  pending,
        input  ptr
    );

    modport slave (
        input  req,
        input  mask,
        input  ack,
        output grant,
        output valid,
        output pending,
        output ptr
    );
endinterface

// File: rtl/request_arbiter.sv
// Round-robin arbiter: sticky pending capture, one held one-hot grant
// at a time, released by ack.
module request_arbiter #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    request_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state_q, state_n;
    logic [N-1:0] pending_q, pending_n;
    logic [N-1:0] grant_q, grant_n;
    logic [4:0]   ptr_q, ptr_n;
    logic [4:0]   gidx_q, gidx_n;
    logic [N-1:0] clr;
    logic [N-1:0] eligible;
    logic         found;
    logic [4:0]   sel;

    assign eligible = pending_q & bus.mask;

    // Scan from ptr upward with 5-bit wrap; first hit wins.
    always_comb begin
        found = 1'b0;
        sel   = 5'd0;
        for (int i = 0; i < N; i++) begin
            logic [4:0] idx;
            idx = ptr_q + 5'(i);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        gidx_n  = gidx_q;
        ptr_n   = ptr_q;
        clr     = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_n      = '0;
                    grant_n[sel] = 1'b1;
                    gidx_n       = sel;
                    state_n      = GRANT;
                end
            end
            GRANT: begin
                if (bus.ack) begin
                    clr     = grant_q;
                    ptr_n   = gidx_q + 5'd1;
                    grant_n = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
        // A request arriving with the clearing ack re-arms the bit.
        pending_n = (pending_q & ~clr) | bus.req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            gidx_q    <= 5'd0;
            ptr_q     <= 5'd0;
        end else begin
            state_q   <= state_n;
            pending_q <= pending_n;
            grant_q   <= grant_n;
            gidx_q    <= gidx_n;
            ptr_q     <= ptr_n;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.valid   = (state_q == GRANT);
    assign bus.pending = pending_q;
    assign bus.ptr     = ptr_q;
endmodule

// File: tb/tb_request_arbiter.sv
// Directed bench for request_arbiter: reset, single grant, wrap,
// masking, ack/request collision, stability and async reset.
module tb_request_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    request_arbiter_if #(.N(32)) bus ();

    request_arbiter #(.N(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.mask = '1;
        bus.ack  = 1'b0;
        #1;
        chk("rst_grant", bus.grant, 32'h0);
        chk("rst_valid", {31'd0, bus.valid}, 32'h0);
        chk("rst_pending", bus.pending, 32'h0);
        chk("rst_ptr", {27'd0, bus.ptr}, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // single request, latency 2 edges, hold without ack
        bus.req = 32'h0000_0100;
        tick();
        bus.req = '0;
        chk("single_pend", bus.pending, 32'h0000_0100);
        chk("single_nov", {31'd0, bus.valid}, 32'h0);
        tick();
        chk("single_valid", {31'd0, bus.valid}, 32'h1);
        chk("single_grant", bus.grant, 32'h0000_0100);
        repeat (5) tick();
        chk("single_hold", bus.grant, 32'h0000_0100);
        chk("single_holdv", {31'd0, bus.valid}, 32'h1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("single_ackv", {31'd0, bus.valid}, 32'h0);
        chk("single_ackg", bus.grant, 32'h0);
        chk("single_pend0", bus.pending, 32'h0);
        chk("single_ptr", {27'd0, bus.ptr}, 32'd9);

        // wrap: reset ptr to 0 between edges
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        chk("wrap_ptr0", {27'd0, bus.ptr}, 32'd0);
        bus.req = 32'h8000_0001;
        tick();
        bus.req = '0;
        tick();
        chk("wrap_g1", bus.grant, 32'h0000_0001);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("wrap_ptr1", {27'd0, bus.ptr}, 32'd1);
        chk("wrap_pend", bus.pending, 32'h8000_0000);
        tick();
        chk("wrap_g2", bus.grant, 32'h8000_0000);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("wrap_ptr2", {27'd0, bus.ptr}, 32'd0);
        tick();
        chk("wrap_none", {31'd0, bus.valid}, 32'h0);

        // masking
        bus.mask = 32'hFFFF_FFFB;
        bus.req  = 32'h0000_0006;
        tick();
        bus.req = '0;
        tick();
        chk("mask_g", bus.grant, 32'h0000_0002);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("mask_pend", bus.pending, 32'h0000_0004);
        chk("mask_ptr", {27'd0, bus.ptr}, 32'd2);
        tick();
        chk("mask_blk", {31'd0, bus.valid}, 32'h0);
        bus.mask = '1;
        tick();
        chk("mask_g2", bus.grant, 32'h0000_0004);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("mask_ptr3", {27'd0, bus.ptr}, 32'd3);

        // ack/request collision on bit 3
        bus.req = 32'h0000_0008;
        tick();
        bus.req = '0;
        tick();
        chk("col_g", bus.grant, 32'h0000_0008);
        bus.ack = 1'b1;
        bus.req = 32'h0000_0008;
        tick();
        bus.ack = 1'b0;
        bus.req = '0;
        chk("col_idle", {31'd0, bus.valid}, 32'h0);
        chk("col_pend", bus.pending, 32'h0000_0008);
        chk("col_ptr", {27'd0, bus.ptr}, 32'd4);
        tick();
        chk("col_regrant", bus.grant, 32'h0000_0008);

        // stability: mask drop in GRANT, ack in IDLE
        bus.mask = '0;
        tick();
        tick();
        chk("stab_g", bus.grant, 32'h0000_0008);
        chk("stab_v", {31'd0, bus.valid}, 32'h1);
        bus.ack = 1'b1;
        tick();
        bus.mask = '1;
        tick();
        tick();
        bus.ack = 1'b0;
        chk("idleack_v", {31'd0, bus.valid}, 32'h0);
        chk("idleack_g", bus.grant, 32'h0);
        chk("idleack_p", bus.pending, 32'h0);
        chk("idleack_ptr", {27'd0, bus.ptr}, 32'd4);

        // async reset mid-GRANT
        bus.req = 32'h0000_0010;
        tick();
        bus.req = '0;
        tick();
        chk("ar_g", bus.grant, 32'h0000_0010);
        bus.req = 32'h0000_0001;
        tick();
        bus.req = '0;
        #2 rst = 1'b1;
        #1;
        chk("ar_grant0", bus.grant, 32'h0);
        chk("ar_valid0", {31'd0, bus.valid}, 32'h0);
        chk("ar_pend0", bus.pending, 32'h0);
        chk("ar_ptr0", {27'd0, bus.ptr}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_after", {31'd0, bus.valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
